// File: rtl/s526a_bist_ctrl.sv
// BIST sequencer for one s526a core.
// Clears the core and drives it with LFSR vectors on G1/G2.
// Compacts the six core outputs into a 16-bit MISR signature.
// When finished, reports DONE and PASS against the expected signature.
module s526a_bist_ctrl #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          INIT_CYC = 2
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] NPAT,
    input  logic [15:0] EXP_SIG,
    input  logic [5:0]  CUT_OUT,
    output logic        CUT_G0,
    output logic        CUT_G1,
    output logic        CUT_G2,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] SIG,
    output logic        PASS
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYC);

    state_t      state;
    state_t      next_state;
    logic [15:0] lfsr;
    logic [15:0] misr;
    logic [15:0] pat_cnt;
    logic [3:0]  init_cnt;

    // The LFSR and the MISR share one feedback polynomial (taps 15, 13, 12, 10).
    function automatic logic [15:0] shift_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // State register.
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero pattern count skips RUN and FLUSH entirely.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                if (init_cnt == 4'd1) begin
                    next_state = (pat_cnt == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pat_cnt == 16'd1) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // LFSR, MISR and counters.
    // FLUSH clocks the MISR once more to capture the response to the last vector.
    always_ff @(posedge CK) begin
        if (RST) begin
            lfsr     <= SEED;
            misr     <= 16'd0;
            pat_cnt  <= 16'd0;
            init_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        lfsr     <= SEED;
                        misr     <= 16'd0;
                        pat_cnt  <= NPAT;
                        init_cnt <= INIT_LOAD;
                    end
                end
                ST_INIT: begin
                    init_cnt <= init_cnt - 4'd1;
                end
                ST_RUN: begin
                    lfsr    <= shift_step(lfsr);
                    misr    <= shift_step(misr) ^ {10'd0, CUT_OUT};
                    pat_cnt <= pat_cnt - 16'd1;
                end
                ST_FLUSH: begin
                    misr <= shift_step(misr) ^ {10'd0, CUT_OUT};
                end
                default: begin
                    lfsr <= lfsr;
                end
            endcase
        end
    end

    // Output decode. Outputs depend only on registered state, except that PASS
    // also compares against EXP_SIG continuously.
    always_comb begin
        CUT_G0 = (state == ST_INIT);
        CUT_G1 = (state == ST_RUN) & lfsr[0];
        CUT_G2 = (state == ST_RUN) & lfsr[1];
        BUSY   = (state == ST_INIT) | (state == ST_RUN) | (state == ST_FLUSH);
        DONE   = (state == ST_DONE);
        SIG    = misr;
        PASS   = (state == ST_DONE) & (misr == EXP_SIG);
    end

endmodule

// File: tb/tb_s526a_bist_ctrl.sv
// Self-checking bench for s526a_bist_ctrl.
// A cycle-count model predicts every output each cycle.
// Directed tests pin the model with hand-computed values.
module tb_s526a_bist_ctrl;

    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          INIT_CYC = 2;

    logic        CK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] NPAT;
    logic [15:0] EXP_SIG;
    logic [5:0]  CUT_OUT;
    logic        CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS;
    logic [15:0] SIG;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Stand-in core: a small registered circuit that G0 clears, so responses lag vectors by one cycle.
    logic [5:0] core_q = 6'd0;
    bit         hold_en = 1'b0;
    logic [5:0] hold_val = 6'd0;

    // Model state: whether a run is active, the cycle index within it, and the expected registers.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_k      = 0;
    int          m_npat   = 0;
    logic [15:0] m_lfsr   = SEED;
    logic [15:0] m_misr   = 16'd0;

    s526a_bist_ctrl #(.SEED(SEED), .INIT_CYC(INIT_CYC)) dut (
        .CK(CK), .RST(RST), .START(START), .NPAT(NPAT), .EXP_SIG(EXP_SIG),
        .CUT_OUT(CUT_OUT), .CUT_G0(CUT_G0), .CUT_G1(CUT_G1), .CUT_G2(CUT_G2),
        .BUSY(BUSY), .DONE(DONE), .SIG(SIG), .PASS(PASS)
    );

    // Clock generation.
    always #5 CK = ~CK;

    assign CUT_OUT = hold_en ? hold_val : core_q;

    // Stand-in core register.
    always @(posedge CK) begin
        core_q <= CUT_G0 ? 6'd0 : ({core_q[4:0], core_q[5] ^ CUT_G1} ^ {4'd0, CUT_G2, CUT_G1});
    end

    function automatic logic [15:0] poly_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int total_busy(input int npat);
        return INIT_CYC + ((npat > 0) ? npat + 1 : 0);
    endfunction

    // Behavioural model. A run is a window of cycles: INIT_CYC clear cycles, then npat vectors, then one flush.
    always @(posedge CK) begin
        if (RST) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
            m_lfsr   = SEED;
            m_misr   = 16'd0;
        end else if (!m_active && START) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            m_k      = 0;
            m_npat   = int'(NPAT);
            m_lfsr   = SEED;
            m_misr   = 16'd0;
        end else if (m_active) begin
            if (m_k >= INIT_CYC && m_k < INIT_CYC + m_npat) begin
                m_misr = poly_step(m_misr) ^ {10'd0, CUT_OUT};
                m_lfsr = poly_step(m_lfsr);
            end else if (m_npat > 0 && m_k == INIT_CYC + m_npat) begin
                m_misr = poly_step(m_misr) ^ {10'd0, CUT_OUT};
            end
            m_k = m_k + 1;
            if (m_k == total_busy(m_npat)) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge CK) begin
        if (check_en) begin
            bit in_run;
            in_run = m_active && m_k >= INIT_CYC && m_k < INIT_CYC + m_npat;
            check_output("BUSY",   32'(BUSY),   32'(m_active));
            check_output("DONE",   32'(DONE),   32'(m_done));
            check_output("CUT_G0", 32'(CUT_G0), 32'(m_active && m_k < INIT_CYC));
            check_output("CUT_G1", 32'(CUT_G1), 32'(in_run & m_lfsr[0]));
            check_output("CUT_G2", 32'(CUT_G2), 32'(in_run & m_lfsr[1]));
            check_output("SIG",    32'(SIG),    32'(m_misr));
            check_output("PASS",   32'(PASS),   32'(m_done && m_misr == EXP_SIG));
        end
    end

    // Issue a one-cycle START with the given pattern count; returns on the negedge after the start edge.
    task automatic apply_stimulus(input logic [15:0] npat);
        @(negedge CK);
        NPAT  = npat;
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
    endtask

    // Count BUSY/G0 cycles until DONE, optionally pulsing START, and record the first two (G1,G2) vectors.
    task automatic run_and_count(input int pulse_a, input int pulse_b,
                                 output int busy_cyc, output int g0_cyc,
                                 output logic [1:0] v0, output logic [1:0] v1);
        int n;
        int vi;
        busy_cyc = 0;
        g0_cyc   = 0;
        v0       = 2'bxx;
        v1       = 2'bxx;
        n        = 0;
        vi       = 0;
        while (!DONE && n < 500) begin
            if (BUSY) busy_cyc = busy_cyc + 1;
            if (CUT_G0) g0_cyc = g0_cyc + 1;
            if (BUSY && !CUT_G0 && vi < 2) begin
                if (vi == 0) v0 = {CUT_G1, CUT_G2};
                else v1 = {CUT_G1, CUT_G2};
                vi = vi + 1;
            end
            START = (n == pulse_a || n == pulse_b);
            n = n + 1;
            @(negedge CK);
        end
        START = 1'b0;
        if (!DONE) check_output("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int busy_cyc, g0_cyc, idle_busy;
        logic [1:0] v0, v1;
        logic [15:0] sig_a, sig_b, gold;

        RST = 1'b1; START = 1'b0; NPAT = 16'd0; EXP_SIG = 16'd0;

        // Reset for two cycles, all outputs zero.
        repeat (2) @(negedge CK);
        check_output("reset_outs", 32'({CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS, SIG}), 32'd0);
        check_en = 1'b1;
        RST = 1'b0;
        idle_busy = 0;
        repeat (10) begin
            @(negedge CK);
            if (BUSY) idle_busy = idle_busy + 1;
        end
        check_output("idle_busy", 32'(idle_busy), 32'd0);

        // NPAT=4 sequencing.
        apply_stimulus(16'd4);
        run_and_count(-1, -1, busy_cyc, g0_cyc, v0, v1);
        check_output("seq_g0_cycles", 32'(g0_cyc), 32'd2);
        check_output("seq_busy_cycles", 32'(busy_cyc), 32'd7);
        check_output("seq_vec0", 32'(v0), 32'b10);
        check_output("seq_vec1", 32'(v1), 32'b11);
        check_output("seq_done", 32'(DONE), 32'd1);

        // NPAT=1 with CUT_OUT held at 1 gives signature 0x0003.
        hold_en = 1'b1; hold_val = 6'h01;
        apply_stimulus(16'd1);
        run_and_count(-1, -1, busy_cyc, g0_cyc, v0, v1);
        check_output("sig_npat1", 32'(SIG), 32'h0003);
        #2 EXP_SIG = 16'h0003;
        #1 check_output("pass_match", 32'(PASS), 32'd1);
        EXP_SIG = 16'h0004;
        #1 check_output("pass_mismatch", 32'(PASS), 32'd0);
        hold_en = 1'b0;

        // NPAT=0: only clear cycles, signature stays zero.
        apply_stimulus(16'd0);
        run_and_count(-1, -1, busy_cyc, g0_cyc, v0, v1);
        check_output("npat0_busy", 32'(busy_cyc), 32'd2);
        check_output("npat0_sig", 32'(SIG), 32'h0000);

        // START pulses during RUN do not change the cycle count.
        apply_stimulus(16'd8);
        run_and_count(3, 5, busy_cyc, g0_cyc, v0, v1);
        check_output("ignore_start_busy", 32'(busy_cyc), 32'(total_busy(8)));
        sig_a = SIG;

        // RST during RUN cycle 3 clears all outputs on the next edge.
        apply_stimulus(16'd8);
        repeat (4) @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        check_output("mid_rst_outs", 32'({CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS, SIG}), 32'd0);

        // Identical rerun reproduces the signature.
        apply_stimulus(16'd8);
        run_and_count(-1, -1, busy_cyc, g0_cyc, v0, v1);
        sig_b = SIG;
        check_output("rerun_sig", 32'(sig_b), 32'(sig_a));

        // Back-to-back NPAT=16 runs.
        apply_stimulus(16'd16);
        run_and_count(-1, -1, busy_cyc, g0_cyc, v0, v1);
        sig_a = SIG;
        gold  = m_misr;
        #2 EXP_SIG = gold;
        #1 check_output("b2b_pass1", 32'(PASS), 32'd1);
        apply_stimulus(16'd16);
        check_output("restart_done_low", 32'(DONE), 32'd0);
        check_output("restart_busy_high", 32'(BUSY), 32'd1);
        run_and_count(-1, -1, busy_cyc, g0_cyc, v0, v1);
        check_output("b2b_sig", 32'(SIG), 32'(sig_a));
        check_output("b2b_pass2", 32'(PASS), 32'd1);

        // RST and START together from DONE: reset wins.
        @(negedge CK);
        RST = 1'b1; START = 1'b1;
        @(negedge CK);
        RST = 1'b0; START = 1'b0;
        check_output("rst_wins", 32'({BUSY, DONE, SIG}), 32'd0);
        repeat (2) @(negedge CK);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/s526a_bist_ctrl.md
# s526a_bist_ctrl

Built-in self-test sequencer for the s526a sequential core. On a start request it clears the core, applies a configurable number of pseudo-random input vectors from a 16-bit LFSR, and compacts the core's six outputs into a 16-bit MISR signature. It then reports done and pass/fail against an expected signature. It sits between the test-control register block and one s526a instance, which it drives directly on G0/G1/G2.

## Interface

- `SEED`, 16'hACE1: LFSR load value. Must be nonzero.
- `INIT_CYC`, 2: number of clear cycles (CUT_G0=1) before patterns. Range 1..15.
- `CK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: start request. Sampled only in IDLE and DONE.
- `NPAT` in 16: number of patterns. Sampled with START.
- `EXP_SIG` in 16: expected signature. Compared continuously.
- `CUT_OUT` in 6: core outputs {G214,G213,G199,G198,G148,G147}, with bit0 = G147.
- `CUT_G0` out 1: core clear input.
- `CUT_G1` out 1: core data input 1.
- `CUT_G2` out 1: core data input 2.
- `BUSY` out 1: high in INIT, RUN, FLUSH.
- `DONE` out 1: high in DONE state.
- `SIG` out 16: MISR contents.
- `PASS` out 1: DONE & (SIG == EXP_SIG).

## Operation

- FSM states: IDLE, INIT, RUN, FLUSH, DONE. All outputs are registered or decoded from registered state only.
- Reset: state=IDLE, LFSR=SEED, MISR=0, counters=0.
  - Outputs under reset: CUT_G0=0, CUT_G1=0, CUT_G2=0, BUSY=0, DONE=0, SIG=0, PASS=0.
- IDLE or DONE with START=1:
  - load LFSR=SEED, MISR=0, pattern counter=NPAT, init counter=INIT_CYC;
  - go to INIT.
- START while BUSY is ignored. NPAT changes while BUSY have no effect.
- INIT: CUT_G0=1, CUT_G1=CUT_G2=0.
  - Lasts exactly INIT_CYC cycles.
  - Then go to RUN, or to DONE directly if NPAT was 0. With NPAT=0, MISR stays 0 and there is no FLUSH.
- RUN: CUT_G0=0, CUT_G1=LFSR[0], CUT_G2=LFSR[1]. Every cycle:
  - LFSR <= {LFSR[14:0], LFSR[15]^LFSR[13]^LFSR[12]^LFSR[10]};
  - MISR <= {MISR[14:0], MISR[15]^MISR[13]^MISR[12]^MISR[10]} ^ {10'b0, CUT_OUT};
  - decrement pattern counter.
  - Lasts exactly NPAT cycles, then go to FLUSH.
- FLUSH: one cycle. CUT_G1=CUT_G2=CUT_G0=0. MISR updates once more, capturing the core response to the last vector. LFSR holds. Then go to DONE.
- DONE: SIG held and DONE=1 until START (restart) or RST. CUT_G* stay 0.
- LFSR and MISR hold in IDLE and DONE.
- Widths: all counters are 16-bit, so NPAT=65535 runs without wrap. The init counter is 4-bit.

## Timing

- START high at edge e0 → BUSY=1 and CUT_G0=1 from e0.
- Total BUSY cycles = INIT_CYC + NPAT + 1 (NPAT>0), or INIT_CYC (NPAT=0).
- DONE rises on the edge that ends BUSY. BUSY and DONE are never high together.
- CUT_OUT is sampled in the same cycle as the vector applied one cycle earlier, i.e. the core's registered response.
- RST mid-operation: next edge returns everything to reset values. No partial DONE.
- RST and START high together: RST wins.
- START in DONE restarts immediately. DONE falls and BUSY rises on the same edge.

## Test plan

- Reset check: assert RST for 2 cycles.
  - All outputs 0, state IDLE.
  - START=0 for 10 cycles: BUSY stays 0.
- Sequencing, NPAT=4, INIT_CYC=2:
  - CUT_G0=1 for exactly 2 cycles, BUSY for 7 cycles, then DONE=1.
  - First two vectors: (G1,G2)=(1,0) from 0xACE1, then (1,1) from 0x59C3.
- Signature, NPAT=1, CUT_OUT held at 6'h01: SIG=0x0003.
  - EXP_SIG=0x0003 → PASS=1.
  - EXP_SIG=0x0004 → PASS=0.
- NPAT=0: INIT_CYC cycles of BUSY, then DONE with SIG=0x0000 and no RUN/FLUSH cycles.
- START pulses during RUN are ignored (cycle count unchanged).
  - RST at RUN cycle 3 → all outputs 0 next cycle.
  - A subsequent run with identical stimulus reproduces the same SIG.
- Back-to-back: START in DONE restarts.
  - Two consecutive NPAT=16 runs against the connected s526a produce identical SIG.
  - PASS matches the golden model signature.
